// File: rtl/hdmi_audio_clk_gen.sv
// Audio fs strobe and HDMI ACR CTS/N generator, running in the pixel-clock domain.
// Optional build macro HDMI_AUDIO_FS_SEL_EN adds fs_sel (0: 48 kHz/N=6144, 1: 44.1 kHz/N=6272).
module hdmi_audio_clk_gen #(
  parameter int FREQ_W      = 27,
  parameter int SAMPLE_RATE = 48000,
  parameter int N_VALUE     = 6144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
`ifdef HDMI_AUDIO_FS_SEL_EN
  input  logic              fs_sel,
`endif
  input  logic [FREQ_W-1:0] clk_freq,
  output logic              audio_sample,
  output logic              acr_stb,
  output logic [19:0]       cts,
  output logic [19:0]       n
);

  localparam int          ACC_W   = FREQ_W + 1;
  localparam logic [19:0] CYC_MAX = '1;

  typedef enum logic [1:0] {
    MODE_RESTART,
    MODE_INVALID,
    MODE_IDLE,
    MODE_RUN
  } mode_e;

  logic [FREQ_W-1:0] freq_q;
  logic [FREQ_W-1:0] rate;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  freq_ext;
  logic [19:0]       cyc_cnt;
  logic [19:0]       cyc_cnt_d;
  logic [19:0]       cts_d;
  logic [19:0]       n_new;
  logic [5:0]        smp_cnt;
  logic [5:0]        smp_cnt_d;
  logic [5:0]        win_last;
  logic              sel_change;
  logic              sample_d;
  logic              acr_d;
  mode_e             mode;

`ifdef HDMI_AUDIO_FS_SEL_EN
  logic fs_sel_q;

  assign rate       = fs_sel_q ? FREQ_W'(44100) : FREQ_W'(48000);
  assign win_last   = fs_sel_q ? 6'd48 : 6'd47;
  assign n_new      = fs_sel ? 20'd6272 : 20'd6144;
  assign sel_change = (fs_sel != fs_sel_q);

  always_ff @(posedge clk) begin
    fs_sel_q <= fs_sel;
  end
`else
  assign rate       = FREQ_W'(SAMPLE_RATE);
  assign win_last   = 6'(N_VALUE / 128 - 1);
  assign n_new      = 20'(N_VALUE);
  assign sel_change = 1'b0;
`endif

  assign freq_ext = {1'b0, freq_q};

  // A rate change outranks everything except reset; a slow clock outranks enable.
  always_comb begin
    if ((clk_freq != freq_q) || sel_change) begin
      mode = MODE_RESTART;
    end else if (freq_q < (rate << 1)) begin
      mode = MODE_INVALID;
    end else if (!enable) begin
      mode = MODE_IDLE;
    end else begin
      mode = MODE_RUN;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    acc_d     = acc;
    cyc_cnt_d = cyc_cnt;
    smp_cnt_d = smp_cnt;
    cts_d     = cts;
    sample_d  = 1'b0;
    acr_d     = 1'b0;
    sum       = acc + {1'b0, rate};

    unique case (mode)
      MODE_RESTART, MODE_IDLE: begin
        acc_d     = '0;
        cyc_cnt_d = '0;
        smp_cnt_d = '0;
      end
      MODE_INVALID: begin
        acc_d     = '0;
        cyc_cnt_d = '0;
        smp_cnt_d = '0;
        cts_d     = '0;
      end
      default: begin
        cyc_cnt_d = (cyc_cnt == CYC_MAX) ? CYC_MAX : cyc_cnt + 20'd1;
        if (sum >= freq_ext) begin
          acc_d    = sum - freq_ext;
          sample_d = 1'b1;
          // The strobe that closes a window reports the clocks it spanned, itself included.
          if (smp_cnt == win_last) begin
            cts_d     = (cyc_cnt == CYC_MAX) ? CYC_MAX : cyc_cnt + 20'd1;
            acr_d     = 1'b1;
            cyc_cnt_d = '0;
            smp_cnt_d = '0;
          end else begin
            smp_cnt_d = smp_cnt + 6'd1;
          end
        end else begin
          acc_d = sum;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      freq_q       <= clk_freq;
      acc          <= '0;
      cyc_cnt      <= '0;
      smp_cnt      <= '0;
      audio_sample <= 1'b0;
      acr_stb      <= 1'b0;
      cts          <= '0;
      n            <= n_new;
    end else begin
      freq_q       <= clk_freq;
      acc          <= acc_d;
      cyc_cnt      <= cyc_cnt_d;
      smp_cnt      <= smp_cnt_d;
      audio_sample <= sample_d;
      acr_stb      <= acr_d;
      cts          <= cts_d;
      if (mode == MODE_RESTART) begin
        n <= n_new;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_audio_clk_gen.sv
// Self-checking bench for hdmi_audio_clk_gen: randomized clock rates against a counting model.
// Scaled-down pixel frequencies keep each CTS window to a few hundred cycles.
`timescale 1ns/1ps
module tb_hdmi_audio_clk_gen;

  localparam int FREQ_W = 27;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              enable   = 1'b0;
  logic [FREQ_W-1:0] clk_freq = '0;
`ifdef HDMI_AUDIO_FS_SEL_EN
  logic              fs_sel   = 1'b0;
`endif
  logic              audio_sample;
  logic              acr_stb;
  logic [19:0]       cts;
  logic [19:0]       n;

  int checks   = 0;
  int failures = 0;

  // Reference model: strobes since restart = floor(t*fs/f); window closes at multiples of N/128.
  longint m_freq = 0;
  longint m_t    = 0;
  longint m_prev = 0;
  longint m_cts  = 0;
  longint m_n    = 6144;
  logic   m_as   = 1'b0;
  logic   m_acr  = 1'b0;
  logic   m_sel  = 1'b0;

  hdmi_audio_clk_gen #(
    .FREQ_W     (FREQ_W),
    .SAMPLE_RATE(48000),
    .N_VALUE    (6144)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
`ifdef HDMI_AUDIO_FS_SEL_EN
    .fs_sel      (fs_sel),
`endif
    .clk_freq    (clk_freq),
    .audio_sample(audio_sample),
    .acr_stb     (acr_stb),
    .cts         (cts),
    .n           (n)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint rate_of(input logic sel);
    return sel ? 64'd44100 : 64'd48000;
  endfunction

  function automatic longint win_of(input logic sel);
    return sel ? 64'd49 : 64'd48;
  endfunction

  function automatic longint n_of(input logic sel);
    return sel ? 64'd6272 : 64'd6144;
  endfunction

  task automatic model_edge();
    logic   sel_now;
    longint k;
    longint kp;
    sel_now = 1'b0;
`ifdef HDMI_AUDIO_FS_SEL_EN
    sel_now = fs_sel;
`endif
    m_as  = 1'b0;
    m_acr = 1'b0;
    if (reset) begin
      m_freq = longint'(clk_freq);
      m_sel  = sel_now;
      m_n    = n_of(sel_now);
      m_t    = 0;
      m_prev = 0;
      m_cts  = 0;
    end else if (longint'(clk_freq) != m_freq || sel_now != m_sel) begin
      m_freq = longint'(clk_freq);
      m_sel  = sel_now;
      m_n    = n_of(sel_now);
      m_t    = 0;
      m_prev = 0;
    end else if (m_freq < 2 * rate_of(m_sel)) begin
      m_t    = 0;
      m_prev = 0;
      m_cts  = 0;
    end else if (!enable) begin
      m_t    = 0;
      m_prev = 0;
    end else begin
      m_t   = m_t + 1;
      k     = (m_t * rate_of(m_sel)) / m_freq;
      kp    = ((m_t - 1) * rate_of(m_sel)) / m_freq;
      m_as  = (k != kp);
      m_acr = m_as && ((k % win_of(m_sel)) == 0);
      if (m_acr) begin
        m_cts  = m_t - m_prev;
        m_prev = m_t;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    enable   = 1'b1;
    clk_freq = 27'd48_000_000;
    repeat (3) tick();
    checks++;
    if (audio_sample !== 1'b0) begin
      failures++;
      $display("FAIL reset_audio_sample got=%0b want=0", audio_sample);
    end
    checks++;
    if (acr_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_acr_stb got=%0b want=0", acr_stb);
    end
    checks++;
    if (cts !== 20'd0) begin
      failures++;
      $display("FAIL reset_cts got=%0d want=0", cts);
    end
    checks++;
    if (n !== 20'd6144) begin
      failures++;
      $display("FAIL reset_n got=%0d want=6144", n);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_strobe_48m();
    int first = -1;
    int nstb  = 0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_48m cyc=%0d got as=%0b acr=%0b cts=%0d n=%0d want as=%0b acr=%0b cts=%0d n=%0d",
                 i, audio_sample, acr_stb, cts, n, m_as, m_acr, m_cts, m_n);
      end
      if (audio_sample === 1'b1) begin
        nstb++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != 1000) begin
      failures++;
      $display("FAIL first_strobe_48m got=%0d want=1000", first);
    end
    checks++;
    if (nstb != 1) begin
      failures++;
      $display("FAIL strobe_count_48m got=%0d want=1", nstb);
    end
  endtask

  task automatic test_integral_cts();
    int last = 0;
    int nacr = 0;
    clk_freq = 27'd4_800_000;
    tick();
    for (int i = 1; i <= 9610; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_4m8 cyc=%0d got as=%0b acr=%0b cts=%0d n=%0d want as=%0b acr=%0b cts=%0d n=%0d",
                 i, audio_sample, acr_stb, cts, n, m_as, m_acr, m_cts, m_n);
      end
      if (audio_sample === 1'b1) begin
        checks++;
        if (i - last != 100) begin
          failures++;
          $display("FAIL interval_4m8 cyc=%0d got=%0d want=100", i, i - last);
        end
        last = i;
      end
      if (acr_stb === 1'b1) begin
        nacr++;
        checks++;
        if (cts !== 20'd4800) begin
          failures++;
          $display("FAIL cts_4m8 cyc=%0d got=%0d want=4800", i, cts);
        end
      end
    end
    checks++;
    if (nacr != 2) begin
      failures++;
      $display("FAIL acr_count_4m8 got=%0d want=2", nacr);
    end
  endtask

  task automatic test_random_rates();
    longint f;
    for (int r = 0; r < 4; r++) begin
      int     last = 0;
      int     nacr = 0;
      int     len;
      longint lo;
      longint hi;
      longint clo;
      longint chi;
      f = (r == 0) ? 64'd742_500 : longint'($urandom_range(96_000, 600_000));
      if (f == longint'(clk_freq)) f = f + 1;
      clk_freq = FREQ_W'(f);
      tick();
      lo  = f / 48000;
      hi  = lo + ((f % 48000) != 0 ? 1 : 0);
      clo = f / 1000;
      chi = clo + ((f % 1000) != 0 ? 1 : 0);
      len = int'(2 * f / 1000 + 5);
      for (int i = 1; i <= len; i++) begin
        tick();
        checks++;
        if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
          failures++;
          $display("FAIL model_rand f=%0d cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                   f, i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
        end
        if (audio_sample === 1'b1) begin
          checks++;
          if (longint'(i - last) != lo && longint'(i - last) != hi) begin
            failures++;
            $display("FAIL interval_rand f=%0d cyc=%0d got=%0d want=%0d or %0d", f, i, i - last, lo, hi);
          end
          last = i;
        end
        if (acr_stb === 1'b1) begin
          nacr++;
          checks++;
          if (longint'(cts) != clo && longint'(cts) != chi) begin
            failures++;
            $display("FAIL cts_rand f=%0d got=%0d want=%0d or %0d", f, cts, clo, chi);
          end
        end
      end
      checks++;
      if (nacr != 2) begin
        failures++;
        $display("FAIL acr_count_rand f=%0d got=%0d want=2", f, nacr);
      end
    end
  endtask

  task automatic test_freq_change();
    int nacr  = 0;
    int stray = 0;
    int hit   = 0;
    clk_freq = 27'd251_000;
    tick();
    for (int i = 1; i <= 602; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_251k cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
      if (acr_stb === 1'b1) begin
        nacr++;
        checks++;
        if (cts !== 20'd251) begin
          failures++;
          $display("FAIL cts_251k got=%0d want=251", cts);
        end
      end
    end
    checks++;
    if (nacr != 2) begin
      failures++;
      $display("FAIL acr_count_251k got=%0d want=2", nacr);
    end
    clk_freq = 27'd280_000;
    tick();
    checks++;
    if (audio_sample !== 1'b0 || acr_stb !== 1'b0 || cts !== 20'd251) begin
      failures++;
      $display("FAIL restart_cycle got as=%0b acr=%0b cts=%0d want as=0 acr=0 cts=251",
               audio_sample, acr_stb, cts);
    end
    for (int i = 1; i <= 300; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_280k cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
      if (i < 280 && acr_stb === 1'b1) stray++;
      if (i == 279) begin
        checks++;
        if (cts !== 20'd251) begin
          failures++;
          $display("FAIL cts_hold_280k got=%0d want=251", cts);
        end
      end
      if (i == 280) begin
        hit = 1;
        checks++;
        if (acr_stb !== 1'b1 || cts !== 20'd280) begin
          failures++;
          $display("FAIL cts_280k got acr=%0b cts=%0d want acr=1 cts=280", acr_stb, cts);
        end
      end
    end
    checks++;
    if (stray != 0 || hit != 1) begin
      failures++;
      $display("FAIL partial_window_280k got stray=%0d hit=%0d want stray=0 hit=1", stray, hit);
    end
  endtask

  task automatic test_invalid_then_enable();
    int active = 0;
    int first  = -1;
    clk_freq = 27'd50_000;
    tick();
    for (int i = 1; i <= 300; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_invalid cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
      if (audio_sample === 1'b1 || acr_stb === 1'b1) active++;
    end
    checks++;
    if (active != 0 || cts !== 20'd0) begin
      failures++;
      $display("FAIL invalid_freq got pulses=%0d cts=%0d want pulses=0 cts=0", active, cts);
    end
    enable   = 1'b0;
    clk_freq = 27'd48_000_000;
    tick();
    tick();
    enable = 1'b1;
    for (int i = 1; i <= 1010; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_reenable cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
      if (audio_sample === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != 1000) begin
      failures++;
      $display("FAIL first_strobe_reenable got=%0d want=1000", first);
    end
  endtask

  task automatic test_enable_toggle();
    int gap;
    int nacr = 0;
    clk_freq = 27'd480_000;
    tick();
    for (int i = 1; i <= 600; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_480k cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
    end
    enable = 1'b0;
    gap    = int'($urandom_range(1, 20));
    for (int i = 1; i <= gap; i++) begin
      tick();
      checks++;
      if (audio_sample !== 1'b0 || acr_stb !== 1'b0 || cts !== 20'd480) begin
        failures++;
        $display("FAIL disabled cyc=%0d got as=%0b acr=%0b cts=%0d want as=0 acr=0 cts=480",
                 i, audio_sample, acr_stb, cts);
      end
    end
    enable = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_enable cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
      if (acr_stb === 1'b1) begin
        nacr++;
        checks++;
        if (i != 480 || cts !== 20'd480) begin
          failures++;
          $display("FAIL acr_after_enable got cyc=%0d cts=%0d want cyc=480 cts=480", i, cts);
        end
      end
    end
    checks++;
    if (nacr != 1) begin
      failures++;
      $display("FAIL acr_count_enable got=%0d want=1", nacr);
    end
  endtask

  task automatic test_reset_mid_window();
    int nacr = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_prereset cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (audio_sample !== 1'b0 || acr_stb !== 1'b0 || cts !== 20'd0 || n !== 20'd6144) begin
      failures++;
      $display("FAIL reset_mid_window got as=%0b acr=%0b cts=%0d n=%0d want as=0 acr=0 cts=0 n=6144",
               audio_sample, acr_stb, cts, n);
    end
    for (int i = 1; i <= 500; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_postreset cyc=%0d got as=%0b acr=%0b cts=%0d want as=%0b acr=%0b cts=%0d",
                 i, audio_sample, acr_stb, cts, m_as, m_acr, m_cts);
      end
      if (acr_stb === 1'b1) begin
        nacr++;
        checks++;
        if (i != 480 || cts !== 20'd480) begin
          failures++;
          $display("FAIL acr_after_reset got cyc=%0d cts=%0d want cyc=480 cts=480", i, cts);
        end
      end
    end
    checks++;
    if (nacr != 1) begin
      failures++;
      $display("FAIL acr_count_reset got=%0d want=1", nacr);
    end
  endtask

`ifdef HDMI_AUDIO_FS_SEL_EN
  task automatic test_fs_sel();
    int last = 0;
    int nacr = 0;
    fs_sel   = 1'b1;
    clk_freq = 27'd441_000;
    tick();
    for (int i = 1; i <= 1000; i++) begin
      tick();
      checks++;
      if (audio_sample !== m_as || acr_stb !== m_acr || cts !== 20'(m_cts) || n !== 20'(m_n)) begin
        failures++;
        $display("FAIL model_fs_sel cyc=%0d got as=%0b acr=%0b cts=%0d n=%0d want as=%0b acr=%0b cts=%0d n=%0d",
                 i, audio_sample, acr_stb, cts, n, m_as, m_acr, m_cts, m_n);
      end
      if (audio_sample === 1'b1) begin
        checks++;
        if (i - last != 10) begin
          failures++;
          $display("FAIL interval_fs_sel cyc=%0d got=%0d want=10", i, i - last);
        end
        last = i;
      end
      if (acr_stb === 1'b1) begin
        nacr++;
        checks++;
        if (cts !== 20'd490 || n !== 20'd6272) begin
          failures++;
          $display("FAIL acr_fs_sel got cts=%0d n=%0d want cts=490 n=6272", cts, n);
        end
      end
    end
    checks++;
    if (nacr != 2) begin
      failures++;
      $display("FAIL acr_count_fs_sel got=%0d want=2", nacr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_strobe_48m();
    test_integral_cts();
    test_random_rates();
    test_freq_change();
    test_invalid_then_enable();
    test_enable_toggle();
    test_reset_mid_window();
`ifdef HDMI_AUDIO_FS_SEL_EN
    test_fs_sel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
